// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
// ID-stage hazard unit for a 5-stage RISC-V pipeline. Every architectural
// register except x0 has a countdown of the cycles left until its pending
// result can be forwarded. ID is stalled on read-after-write conflicts, and on
// write-after-write conflicts where the younger write would land first.
// A saturating counter records the number of stalled cycles.
module hazard_scoreboard_unit #(
    parameter  int NUM_REGS    = 32,
    parameter  int REG_AW      = 5,
    parameter  int MAX_LAT     = 4,
    parameter  int STALL_CNT_W = 16,
    localparam int CNT_W       = $clog2(MAX_LAT + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rs1,
    input  logic [REG_AW-1:0]      id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_rd_wen,
    input  logic [CNT_W-1:0]       id_lat,
    input  logic                   flush,
    input  logic                   stall_cnt_clr,
    output logic                   stall,
    output logic [NUM_REGS-1:0]    busy_vec,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0]       MAX_LAT_C = CNT_W'(MAX_LAT);
    localparam logic [STALL_CNT_W-1:0] SCNT_MAX  = '1;

    // x0 is hardwired zero, so it gets no counter at all.
    logic [CNT_W-1:0]       cnt_q [1:NUM_REGS-1];
    logic [CNT_W-1:0]       cnt_d [1:NUM_REGS-1];
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    logic [CNT_W-1:0] lat_eff;
    logic [CNT_W-1:0] rs1_cnt;
    logic [CNT_W-1:0] rs2_cnt;
    logic [CNT_W-1:0] rd_cnt;
    logic             raw_hazard;
    logic             waw_hazard;
    logic             accept;
    logic             issue;

    // Latency encodings above MAX_LAT are clamped rather than rejected.
    function automatic logic [CNT_W-1:0] clamp_lat(input logic [CNT_W-1:0] lat);
        return (lat > MAX_LAT_C) ? MAX_LAT_C : lat;
    endfunction

    assign lat_eff = clamp_lat(id_lat);

    // Look up the pending counts of the source and destination registers; x0
    // and any address with no counter read as zero.
    always_comb begin
        rs1_cnt = '0;
        rs2_cnt = '0;
        rd_cnt  = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (id_rs1 == REG_AW'(r)) rs1_cnt = cnt_q[r];
            if (id_rs2 == REG_AW'(r)) rs2_cnt = cnt_q[r];
            if (id_rd  == REG_AW'(r)) rd_cnt  = cnt_q[r];
        end
    end

    // Hazards are checked against the old counters, so an instruction whose rd
    // matches one of its sources sees the older producer, not itself.
    always_comb begin
        raw_hazard = (id_use_rs1 && (id_rs1 != '0) && (rs1_cnt != '0)) ||
                     (id_use_rs2 && (id_rs2 != '0) && (rs2_cnt != '0));
        waw_hazard = id_rd_wen && (id_rd != '0) && (rd_cnt > lat_eff);
    end

    assign stall  = id_valid && !flush && (raw_hazard || waw_hazard);
    assign accept = id_valid && !stall && !flush;
    assign issue  = accept && id_rd_wen && (id_rd != '0);

    // An accepted write reloads its register's countdown. Every other nonzero
    // countdown keeps ticking, including during a flush, because instructions
    // that were already issued still complete.
    always_comb begin
        for (int r = 1; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue && (id_rd == REG_AW'(r))) begin
                cnt_d[r] = lat_eff;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Stall counter: a clear takes priority over the increment, and the count
    // holds at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (stall && (stall_cnt_q != SCNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // State registers; reset drops every pending producer immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            stall_cnt_q <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Busy flags mirror the nonzero countdowns; x0 is never busy.
    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy_vec[r] = (cnt_q[r] != '0);
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule
